// File: rtl/register_file_2r1w.sv
// Two-read/one-write register file with r0 hardwired to zero and a sequential clear engine.
// Define RF_BYPASS_EN for write-first forwarding on same-cycle write/read; default is read-first.
module register_file_2r1w #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              clr_start,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic [WIDTH-1:0]  rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0]  rd_data_b_q, rd_data_b_d;
  logic              busy_w;
  logic              wr_accept;
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  clr_hit;

  assign busy_w    = (state_q == CLEAR);
  assign busy      = busy_w;
  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;

  // Writes are only taken while idle; r0 never stores anything.
  assign wr_accept = wr_en && !busy_w && (wr_addr != '0);

  // One-hot write and clear decode per register.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_decode
      assign wr_hit[gi]  = wr_accept && (wr_addr == ADDR_W'(gi));
      assign clr_hit[gi] = busy_w && (idx_q == ADDR_W'(gi));
    end
  endgenerate

  // Clear sequencer: walks idx from 1 to DEPTH-1, one register per cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          idx_d   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (i == 0) begin
        regs_d[i] = '0;
      end else if (clr_hit[i]) begin
        regs_d[i] = '0;
      end else if (wr_hit[i]) begin
        regs_d[i] = wr_data;
      end
    end
  end

  // Read ports: a disabled port holds; busy or r0 reads return zero.
  always_comb begin
    rd_data_a_d = rd_data_a_q;
    if (rd_en_a) begin
      if (busy_w || (rd_addr_a == '0)) begin
        rd_data_a_d = '0;
`ifdef RF_BYPASS_EN
      end else if (wr_accept && (rd_addr_a == wr_addr)) begin
        rd_data_a_d = wr_data;
`endif
      end else begin
        rd_data_a_d = regs_q[rd_addr_a];
      end
    end
  end

  always_comb begin
    rd_data_b_d = rd_data_b_q;
    if (rd_en_b) begin
      if (busy_w || (rd_addr_b == '0)) begin
        rd_data_b_d = '0;
`ifdef RF_BYPASS_EN
      end else if (wr_accept && (rd_addr_b == wr_addr)) begin
        rd_data_b_d = wr_data;
`endif
      end else begin
        rd_data_b_d = regs_q[rd_addr_b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule
